clk_div_multi: RTL and testbench

//   Multi-channel programmable clock-enable generator for game timing: sprite animation, obstacle scroll, score tick.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 93 +++++++++
 rtl/clk_div_multi.sv | 55 +++++
 tb/tb_clk_div_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// default counter width, the reset terminal count, the per-channel
// output mode encoding and the counter/divisor type.
package clk_div_pkg;

   localparam int          CLK_DIV_CNT_W       = 26;
   localparam int unsigned CLK_DIV_DEFAULT_DIV = 32'd50000000;

   typedef enum logic {
      DIV_TICK   = 1'b0,
      DIV_SQUARE = 1'b1
   } div_mode_e;

   typedef logic [CLK_DIV_CNT_W-1:0] div_cnt_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: a counter compared against the active divisor,
// a shadow divisor that waits for the next terminal count, and the
// registered tick / square-wave / pending outputs.
// i_sync is driven only when the top is built with CLK_DIV_SYNC_EN;
// otherwise it is tied low and the sync branch disappears.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int          CNT_W       = CLK_DIV_CNT_W,
   parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
   input  logic             i_clk_in,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_mode,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   input  logic             i_sync,
   output logic             o_tick,
   output logic             o_sq,
   output logic             o_pending
);

   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_act;
   logic [CNT_W-1:0] r_div_shadow;
   logic             r_pending;
   logic             r_tick;
   logic             r_sq;

   div_mode_e        w_mode;
   logic             w_terminal;

   assign w_mode     = div_mode_e'(i_mode);
   assign w_terminal = (r_cnt == r_div_act);

   // Counter, divisor hand-over and registered outputs; reset wins, then a
   // disabled channel parks at zero, then sync, then terminal count, then counting.
   always_ff @(posedge i_clk_in) begin
      if (i_rst) begin
         r_cnt        <= '0;
         r_div_act    <= RESET_DIV;
         r_div_shadow <= RESET_DIV;
         r_pending    <= 1'b0;
         r_tick       <= 1'b0;
         r_sq         <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
         if (i_load) begin
            r_div_act <= i_value;
            r_pending <= 1'b0;
         end
      end else if (i_sync) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
         r_sq   <= 1'b0;
         if (i_load) begin
            r_div_shadow <= i_value;
            r_pending    <= 1'b1;
         end
      end else if (w_terminal) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
         r_sq   <= (w_mode == DIV_SQUARE) ? ~r_sq : 1'b0;
         if (i_load) begin
            r_div_act <= i_value;
            r_pending <= 1'b0;
         end else if (r_pending) begin
            r_div_act <= r_div_shadow;
            r_pending <= 1'b0;
         end
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_tick <= 1'b0;
         if (w_mode == DIV_TICK) begin
            r_sq <= 1'b0;
         end
         if (i_load) begin
            r_div_shadow <= i_value;
            r_pending    <= 1'b1;
         end
      end
   end

   assign o_tick    = r_tick;
   assign o_sq      = r_sq;
   assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator for game timing.
// Each channel divides i_clk_in by its own runtime-loadable divisor and
// emits a one-cycle tick plus an optional square wave. This level only
// fans the shared divisor bus and the sync strobe out to the channels.
// Optional feature: define CLK_DIV_SYNC_EN to add i_sync_all, which
// restarts every enabled channel together for phase alignment.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int          NUM_CH      = 4,
   parameter int          CNT_W       = CLK_DIV_CNT_W,
   parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT_DIV
) (
   input  logic              i_clk_in,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_ch_en,
   input  logic [NUM_CH-1:0] i_mode,
   input  logic [NUM_CH-1:0] i_div_load,
   input  logic [CNT_W-1:0]  i_div_value,
   output logic [NUM_CH-1:0] o_tick_out,
   output logic [NUM_CH-1:0] o_divided_clk,
   output logic [NUM_CH-1:0] o_div_pending
`ifdef CLK_DIV_SYNC_EN
   ,
   input  logic              i_sync_all
`endif
);

   logic w_sync;

`ifdef CLK_DIV_SYNC_EN
   assign w_sync = i_sync_all;
`else
   assign w_sync = 1'b0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
         .i_clk_in  (i_clk_in),
         .i_rst     (i_rst),
         .i_en      (i_ch_en[g]),
         .i_mode    (i_mode[g]),
         .i_load    (i_div_load[g]),
         .i_value   (i_div_value),
         .i_sync    (w_sync),
         .o_tick    (o_tick_out[g]),
         .o_sq      (o_divided_clk[g]),
         .o_pending (o_div_pending[g])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi. A behavioural model tracks, per
// channel, how far into the current period it is, the period length in use
// and any divisor waiting for the next period boundary; outputs are compared
// every cycle, one tick after the active clock edge.
// Build with CLK_DIV_SYNC_EN to also exercise the sync strobe.
module tb_clk_div_multi;
   import clk_div_pkg::*;

   localparam int NUM_CH         = 4;
   localparam int CNT_W          = CLK_DIV_CNT_W;
   localparam int TB_DEFAULT_DIV = 6;
`ifdef CLK_DIV_SYNC_EN
   localparam bit SYNC_BUILD = 1'b1;
`else
   localparam bit SYNC_BUILD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] chEn;
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] divLoad;
   logic [CNT_W-1:0]  divValue;
   logic              syncAll;
   logic [NUM_CH-1:0] tickOut;
   logic [NUM_CH-1:0] dividedClk;
   logic [NUM_CH-1:0] divPending;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model state: position inside the period, period length minus one in
   // use, the waiting divisor, and the expected registered outputs.
   int mPhase  [NUM_CH];
   int mAct    [NUM_CH];
   int mShadow [NUM_CH];
   bit mPend   [NUM_CH];
   bit mTick   [NUM_CH];
   bit mSq     [NUM_CH];

   clk_div_multi #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (TB_DEFAULT_DIV)
   ) dut (
      .i_clk_in      (clk),
      .i_rst         (rst),
      .i_ch_en       (chEn),
      .i_mode        (mode),
      .i_div_load    (divLoad),
      .i_div_value   (divValue),
      .o_tick_out    (tickOut),
      .o_divided_clk (dividedClk),
      .o_div_pending (divPending)
`ifdef CLK_DIV_SYNC_EN
      ,
      .i_sync_all    (syncAll)
`endif
   );

   // Free-running 10 ns system clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance the model by one clock edge using the inputs held at that edge.
   function automatic void modelStep();
      bit syncOn;
      syncOn = SYNC_BUILD & syncAll;
      for (int c = 0; c < NUM_CH; c++) begin
         int  value;
         int  period;
         bit  endOfPeriod;
         value = int'(divValue);
         if (rst) begin
            mPhase[c]  = 0;
            mAct[c]    = TB_DEFAULT_DIV;
            mShadow[c] = TB_DEFAULT_DIV;
            mPend[c]   = 1'b0;
            mTick[c]   = 1'b0;
            mSq[c]     = 1'b0;
         end else if (!chEn[c]) begin
            mPhase[c] = 0;
            mTick[c]  = 1'b0;
            mSq[c]    = 1'b0;
            if (divLoad[c]) begin
               mAct[c]  = value;
               mPend[c] = 1'b0;
            end
         end else if (syncOn) begin
            mPhase[c] = 0;
            mTick[c]  = 1'b0;
            mSq[c]    = 1'b0;
            if (divLoad[c]) begin
               mShadow[c] = value;
               mPend[c]   = 1'b1;
            end
         end else begin
            period      = mAct[c] + 1;
            endOfPeriod = (mPhase[c] + 1 == period);
            if (endOfPeriod) begin
               mPhase[c] = 0;
               mTick[c]  = 1'b1;
               mSq[c]    = mode[c] ? ~mSq[c] : 1'b0;
               if (divLoad[c]) begin
                  mAct[c]  = value;
                  mPend[c] = 1'b0;
               end else if (mPend[c]) begin
                  mAct[c]  = mShadow[c];
                  mPend[c] = 1'b0;
               end
            end else begin
               mPhase[c] = mPhase[c] + 1;
               mTick[c]  = 1'b0;
               if (!mode[c]) mSq[c] = 1'b0;
               if (divLoad[c]) begin
                  mShadow[c] = value;
                  mPend[c]   = 1'b1;
               end
            end
         end
      end
   endfunction

   // One clock: let the edge happen, update the model, compare all outputs.
   task automatic runCycle(input string tag);
      logic [NUM_CH-1:0] expTick;
      logic [NUM_CH-1:0] expSq;
      logic [NUM_CH-1:0] expPend;
      @(posedge clk);
      #1;
      modelStep();
      cyc++;
      for (int c = 0; c < NUM_CH; c++) begin
         expTick[c] = mTick[c];
         expSq[c]   = mSq[c];
         expPend[c] = mPend[c];
      end
      checkOutput($sformatf("%s tick cyc%0d", tag, cyc), 32'(tickOut), 32'(expTick));
      checkOutput($sformatf("%s sq cyc%0d", tag, cyc), 32'(dividedClk), 32'(expSq));
      checkOutput($sformatf("%s pend cyc%0d", tag, cyc), 32'(divPending), 32'(expPend));
   endtask

   task automatic applyStimulus(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         runCycle(tag);
         divLoad = '0;
         syncAll = 1'b0;
         rst     = 1'b0;
      end
   endtask

   task automatic pulseReset(input string tag);
      rst = 1'b1;
      applyStimulus(tag, 1);
   endtask

   initial begin
      rst      = 1'b1;
      chEn     = '0;
      mode     = '0;
      divLoad  = '0;
      divValue = '0;
      syncAll  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         mPhase[c] = 0; mAct[c] = TB_DEFAULT_DIV; mShadow[c] = TB_DEFAULT_DIV;
         mPend[c] = 1'b0; mTick[c] = 1'b0; mSq[c] = 1'b0;
      end

      // Reset state, then reset divisor runs on every channel.
      applyStimulus("reset", 2);
      chEn = '1;
      applyStimulus("defaultDiv", 16);

      // Divisor 4 on ch0 with square wave: tick every 5, square period 10.
      pulseReset("rstA");
      chEn = '0; divLoad = 4'b0001; divValue = CNT_W'(4); mode = 4'b0001;
      applyStimulus("loadIdle", 1);
      chEn = '1;
      applyStimulus("div4", 24);
      pulseReset("rstMid1");

      // Divisor 9 on ch1, shrink to 2 mid-period.
      chEn = '0; divLoad = 4'b0010; divValue = CNT_W'(9); mode = 4'b0011;
      applyStimulus("load9", 1);
      chEn = 4'b0010;
      applyStimulus("run9", 4);
      divLoad = 4'b0010; divValue = CNT_W'(2);
      applyStimulus("shrink", 20);

      // Load exactly at ch2 terminal count: bypasses the shadow.
      chEn = 4'b0110;
      for (int i = 0; i < 20; i++) begin
         if (mPhase[2] == mAct[2]) begin
            divLoad = 4'b0100; divValue = CNT_W'(3);
            applyStimulus("coincide", 1);
            break;
         end
         applyStimulus("seekTerm", 1);
      end
      applyStimulus("afterCoincide", 12);
      pulseReset("rstMid2");

      // Divisor 0 in square mode on ch3: tick constantly, toggle each cycle.
      chEn = '0; divLoad = 4'b1000; divValue = '0; mode = 4'b1000;
      applyStimulus("load0", 1);
      chEn = 4'b1000;
      applyStimulus("div0", 8);
      mode = 4'b0000;
      applyStimulus("modeOff", 3);

      // Enable drop mid-count and reassert.
      chEn = '0; divLoad = 4'b0001; divValue = CNT_W'(5); mode = 4'b0001;
      applyStimulus("load5", 1);
      chEn = 4'b0001;
      applyStimulus("run5", 3);
      chEn = 4'b0000;
      applyStimulus("enDrop", 3);
      chEn = 4'b0001;
      applyStimulus("enBack", 14);
      pulseReset("rstMid3");

      // Skewed channels realigned by the sync strobe.
      chEn = '0; divLoad = 4'b0011; divValue = CNT_W'(3); mode = 4'b0011;
      applyStimulus("loadA", 1);
      divLoad = 4'b0010; divValue = CNT_W'(7);
      applyStimulus("loadB", 1);
      chEn = 4'b0001;
      applyStimulus("skew", 2);
      chEn = 4'b0011;
      applyStimulus("skewRun", 5);
      syncAll = 1'b1;
      applyStimulus("sync", 1);
      applyStimulus("aligned", 18);

      // Randomised traffic against the model.
      pulseReset("rstRand");
      chEn = '1;
      for (int i = 0; i < 2000; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 19) == 0) chEn[c] = ~chEn[c];
            if ($urandom_range(0, 15) == 0) mode[c] = ~mode[c];
            divLoad[c] = ($urandom_range(0, 9) == 0);
         end
         divValue = CNT_W'($urandom_range(0, 9));
         syncAll  = ($urandom_range(0, 39) == 0);
         rst      = ($urandom_range(0, 149) == 0);
         applyStimulus("rand", 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
